// File: rtl/shift_left_8bit_seq.sv
// Multi-cycle logical left shifter: shifts a_i left by min(b_i, WIDTH), one bit per clock, zero fill.
// Optional carry-out of the last shifted bit is enabled by defining SHL_CARRY_EN.
module shift_left_8bit_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] c_o,
  output logic [1:0]       state_o
`ifdef SHL_CARRY_EN
  ,
  output logic             carry_o
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshakes: a request is accepted on a rising edge where start_i & ready_o;
  // a result is consumed on a rising edge where valid_o & ready_i. Both sides hold
  // their payload stable until the corresponding handshake completes.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [31:0]      b_ext;
  logic [CW-1:0]    amt;

  assign b_ext = 32'(b_i);
  assign amt   = (b_ext > 32'(WIDTH)) ? CW'(WIDTH) : CW'(b_ext);

`ifdef SHL_CARRY_EN
  logic carry_q, carry_d;
  // Set when the request asked for more than WIDTH positions: carry stays 0.
  logic sat_q, sat_d;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef SHL_CARRY_EN
    carry_d = carry_q;
    sat_d   = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          data_d  = a_i;
          cnt_d   = amt;
`ifdef SHL_CARRY_EN
          carry_d = 1'b0;
          sat_d   = (b_ext > 32'(WIDTH));
`endif
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = {data_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
`ifdef SHL_CARRY_EN
        if (!sat_q) begin
          carry_d = data_q[WIDTH-1];
        end
`endif
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef SHL_CARRY_EN
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef SHL_CARRY_EN
      carry_q <= carry_d;
      sat_q   <= sat_d;
`endif
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign c_o     = data_q;
  assign state_o = state_q;
`ifdef SHL_CARRY_EN
  assign carry_o = carry_q;
`endif

endmodule
